// File: rtl/ps2_pkg.sv
// PS/2 device-side transmitter: shared constants, state encoding and frame helpers.
package ps2_pkg;

    localparam logic [7:0]  PS2_BREAK_PREFIX = 8'hF0;
    localparam int unsigned PS2_FRAME_BITS   = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREFIX,
        ST_BYTE,
        ST_GAP
    } tx_state_e;

    // Parity bit that makes data ones plus parity an odd total.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    // Frame in transmit order from bit 0: start, data LSB first, parity, stop.
    function automatic logic [PS2_FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {1'b1, odd_parity(data), data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_tx_byte.sv
// Serializes one byte as an 11-bit PS/2 device frame.
// Ports:
//   clk, rst       system clock, async active-high reset
//   start_i        load byte_i and drive the start bit on the next cycle
//   byte_i         byte to send (sampled only when start_i=1)
//   ps2_clk_o      registered PS/2 clock (idle 1)
//   ps2_data_o     registered PS/2 data (idle 1)
//   done_o         one-cycle pulse during the last stop-bit cycle
module ps2_tx_byte
    import ps2_pkg::*;
#(
    parameter int unsigned HALF = 2500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       ps2_clk_o,
    output logic       ps2_data_o,
    output logic       done_o
);

    localparam int unsigned CW = $clog2(2 * HALF);
    localparam int unsigned BW = $clog2(PS2_FRAME_BITS);
    localparam int unsigned FW = PS2_FRAME_BITS;

    localparam logic [CW-1:0] CYC_FALL = CW'(HALF - 1);
    localparam logic [CW-1:0] CYC_PRE  = CW'(2 * HALF - 2);
    localparam logic [CW-1:0] CYC_LAST = CW'(2 * HALF - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(PS2_FRAME_BITS - 1);

    logic          busy_q,  busy_d;
    logic [CW-1:0] cyc_q,   cyc_d;
    logic [BW-1:0] bit_q,   bit_d;
    logic [FW-1:0] shift_q, shift_d;
    logic          clk_q,   clk_d;
    logic          data_q,  data_d;
    logic          done_q,  done_d;

    // State registers; lines idle high in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            clk_q   <= 1'b1;
            data_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            clk_q   <= clk_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // Bit timing: data moves only at bit boundaries, where ps2_clk returns high.
    always_comb begin
        busy_d  = busy_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        clk_d   = clk_q;
        data_d  = data_q;
        done_d  = 1'b0;

        if (start_i) begin
            busy_d  = 1'b1;
            cyc_d   = '0;
            bit_d   = '0;
            shift_d = build_frame(byte_i);
            clk_d   = 1'b1;
            data_d  = 1'b0;
        end else if (busy_q) begin
            cyc_d = cyc_q + CW'(1);
            if (cyc_q == CYC_FALL) begin
                clk_d = 1'b0;
            end
            // Registered done lands on the final stop-bit cycle.
            if (cyc_q == CYC_PRE && bit_q == BIT_LAST) begin
                done_d = 1'b1;
            end
            if (cyc_q == CYC_LAST) begin
                cyc_d = '0;
                clk_d = 1'b1;
                if (bit_q == BIT_LAST) begin
                    busy_d  = 1'b0;
                    bit_d   = '0;
                    shift_d = '0;
                    data_d  = 1'b1;
                end else begin
                    bit_d   = bit_q + BW'(1);
                    shift_d = shift_q >> 1;
                    data_d  = shift_q[1];
                end
            end
        end
    end

    assign ps2_clk_o  = clk_q;
    assign ps2_data_o = data_q;
    assign done_o     = done_q;

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard transmitter: sends a scancode, optionally preceded by the
// 0xF0 break prefix, with an idle gap after every byte.
// Ports:
//   clk, rst    system clock, async active-high reset
//   code        scancode to send
//   brk         1 = release (prefix 0xF0 then code), 0 = press (code only)
//   valid       request qualifier, accepted when ready=1
//   ready       block idle
//   ps2_clk     PS/2 clock to host (idle 1)
//   ps2_data    PS/2 data to host (idle 1)
//   count       bytes fully transmitted, wraps
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int unsigned HALF = 2500,
    parameter int unsigned GAP  = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code,
    input  logic       brk,
    input  logic       valid,
    output logic       ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic [7:0] count
);

    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    tx_state_e     state_q, state_d;
    logic [7:0]    code_q,  code_d;
    logic          pend_q,  pend_d;
    logic [GW-1:0] gap_q,   gap_d;
    logic          ready_q, ready_d;
    logic [7:0]    count_q, count_d;

    logic          tx_start_c;
    logic [7:0]    tx_byte_c;
    logic          tx_done;

    ps2_tx_byte #(
        .HALF(HALF)
    ) u_tx_byte (
        .clk       (clk),
        .rst       (rst),
        .start_i   (tx_start_c),
        .byte_i    (tx_byte_c),
        .ps2_clk_o (ps2_clk),
        .ps2_data_o(ps2_data),
        .done_o    (tx_done)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            pend_q  <= 1'b0;
            gap_q   <= '0;
            ready_q <= 1'b1;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pend_q  <= pend_d;
            gap_q   <= gap_d;
            ready_q <= ready_d;
            count_q <= count_d;
        end
    end

    // Sequencing: prefix -> gap -> byte -> gap -> idle. pend_q marks that
    // the scancode still follows the current gap.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        pend_d     = pend_q;
        gap_d      = gap_q;
        count_d    = count_q + 8'(tx_done);
        tx_start_c = 1'b0;
        tx_byte_c  = code_q;

        case (state_q)
            ST_IDLE: begin
                // Input byte feeds the serializer directly so the start bit
                // appears on the cycle after accept.
                if (valid) begin
                    code_d     = code;
                    pend_d     = brk;
                    tx_start_c = 1'b1;
                    tx_byte_c  = brk ? PS2_BREAK_PREFIX : code;
                    state_d    = brk ? ST_PREFIX : ST_BYTE;
                end
            end
            ST_PREFIX: begin
                if (tx_done) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end
            end
            ST_BYTE: begin
                if (tx_done) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    if (pend_q) begin
                        pend_d     = 1'b0;
                        tx_start_c = 1'b1;
                        tx_byte_c  = code_q;
                        state_d    = ST_BYTE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    assign ready = ready_q;
    assign count = count_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx with HALF=4, GAP=8.
module tb_ps2_kbd_tx;

    localparam int unsigned HALF = 4;
    localparam int unsigned GAP  = 8;
    localparam int          T1   = 22 * HALF + GAP;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] code;
    logic       brk;
    logic       valid;
    logic       ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] count;

    int n_pass  = 0;
    int n_total = 0;
    int viol    = 0;
    logic prev_data = 1'b1;
    logic rx_q[$];

    always #5 clk = ~clk;

    ps2_kbd_tx #(
        .HALF(HALF),
        .GAP (GAP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .code    (code),
        .brk     (brk),
        .valid   (valid),
        .ready   (ready),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .count   (count)
    );

    // Host receiver: sample data on each ps2_clk falling edge.
    always @(negedge ps2_clk) begin
        if (rst !== 1'b1) rx_q.push_back(ps2_data);
    end

    // Record any data change seen while ps2_clk is low.
    always @(negedge clk) begin
        if (ps2_data !== prev_data && ps2_clk !== 1'b1) viol++;
        prev_data = ps2_data;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_frame(input string tag, input logic [10:0] exp);
        logic [10:0] f;
        f = '0;
        if (rx_q.size() < 11) begin
            chk({tag, " bits"}, rx_q.size(), 11);
        end else begin
            for (int i = 0; i < 11; i++) f[i] = rx_q.pop_front();
            chk(tag, f, exp);
        end
    endtask

    // Cycles from start bit to ready, first ps2_clk low cycle, longest idle run.
    task automatic wait_ready(output int cyc, output int fall, output int maxrun);
        int run;
        cyc = 0; fall = -1; run = 0; maxrun = 0;
        while (ready !== 1'b1 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            if (fall < 0 && ps2_clk === 1'b0) fall = cyc;
            if (ps2_clk === 1'b1 && ps2_data === 1'b1) begin
                run++;
            end else begin
                if (run > maxrun) maxrun = run;
                run = 0;
            end
        end
    endtask

    task automatic send(input logic [7:0] c, input logic b, input int exp_cyc,
                        input string tag, output int maxrun);
        int cyc, fall;
        code = c; brk = b; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        chk({tag, " start"}, {ready, ps2_clk, ps2_data}, 3'b010);
        wait_ready(cyc, fall, maxrun);
        chk({tag, " latency"}, cyc, exp_cyc);
        chk({tag, " first fall"}, fall, HALF);
    endtask

    initial begin
        int cyc, fall, run;
        logic [7:0] b;

        rst = 1'b1; valid = 1'b0; code = 8'h00; brk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset lines", {ps2_clk, ps2_data, ready}, 3'b111);
        chk("reset count", count, 8'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post-reset lines", {ps2_clk, ps2_data, ready}, 3'b111);

        // Press 0x1C: 0,00111000,0,1
        send(8'h1C, 1'b0, T1, "press", run);
        chk_frame("press frame", 11'h438);
        chk("press count", count, 8'd1);

        // Release 0x1C: F0 (parity 1), gap, 1C
        send(8'h1C, 1'b1, 2 * T1, "release", run);
        chk("release gap", run, GAP);
        chk_frame("release prefix", 11'h7E0);
        chk_frame("release code", 11'h438);
        chk("release count", count, 8'd3);

        // valid held with a new code while busy
        code = 8'h1C; brk = 1'b0; valid = 1'b1;
        @(posedge clk); #1;
        code = 8'h2A;
        chk("hold start", {ready, ps2_clk, ps2_data}, 3'b010);
        wait_ready(cyc, fall, run);
        chk("hold latency", cyc, T1);
        @(posedge clk); #1;
        valid = 1'b0;
        chk("hold next start", {ready, ps2_clk, ps2_data}, 3'b010);
        wait_ready(cyc, fall, run);
        chk("hold next latency", cyc, T1);
        chk_frame("hold frame", 11'h438);
        chk_frame("hold next frame", 11'h454);
        chk("hold count", count, 8'd5);

        // Reset during data bit 4 of 0x45 (frame bit 5, cycles 40..47)
        code = 8'h45; brk = 1'b0; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (42) @(posedge clk);
        #1;
        chk("abort pre lines", {ps2_clk, ps2_data}, 2'b10);
        rst = 1'b1;
        #1;
        chk("abort lines", {ps2_clk, ps2_data, ready}, 3'b111);
        chk("abort count", count, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rx_q.delete();
        @(posedge clk); #1;
        chk("abort release", {ps2_clk, ps2_data, ready, count}, {3'b111, 8'd0});
        send(8'h45, 1'b0, T1, "after abort", run);
        chk_frame("after abort frame", 11'h48A);
        chk("after abort count", count, 8'd1);

        // 256 back-to-back presses from a cleared counter
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rx_q.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            send(b, 1'b0, T1, "bulk", run);
            chk_frame("bulk frame", {1'b1, ~^b, b, 1'b0});
        end
        chk("bulk count wrap", count, 8'd0);
        chk("data changes only while clk high", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
